// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register so frames can be sent
// back-to-back without an idle gap on the line.
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       data_i_valid,
  output logic       data_i_ready,
  output logic       tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    hold_q;
  logic          hold_full_q;
  logic          tx_q;
  logic          done_q;

  assign data_i_ready = !hold_full_q;
  assign tx_o         = tx_q;
  assign tx_done_o    = done_q;
  assign tx_busy_o    = (state_q != IDLE) || hold_full_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Accept and load are mutually exclusive: ready is low whenever a load can happen.
      if (data_i_valid && !hold_full_q) begin
        hold_q      <= data_i;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            state_q     <= START;
            tx_q        <= 1'b0;
            baud_q      <= '0;
          end
        end
        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          // Raised one cycle early so the registered pulse lands on the final stop cycle.
          if (baud_q == BAUD_PRE) begin
            done_q <= 1'b1;
          end
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (hold_full_q) begin
              shift_q     <= hold_q;
              hold_full_q <= 1'b0;
              tx_q        <= 1'b0;
              state_q     <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: driver pushes accepted bytes, a line monitor checks every
// cycle of each frame against the ideal 8N1 waveform.
module tb_uart_transmitter;

  localparam int unsigned C     = 4;
  localparam int unsigned FRAME = 10 * C;

  logic       clk;
  logic       rst_i;
  logic [7:0] data_i;
  logic       data_i_valid;
  logic       data_i_ready;
  logic       tx_o;
  logic       tx_busy_o;
  logic       tx_done_o;

  uart_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .data_i      (data_i),
    .data_i_valid(data_i_valid),
    .data_i_ready(data_i_ready),
    .tx_o        (tx_o),
    .tx_busy_o   (tx_busy_o),
    .tx_done_o   (tx_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned pushes   = 0;
  int unsigned frames   = 0;
  bit          in_frame = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Line monitor: one evaluation per cycle, away from the active edge.
  initial begin
    bit          rst_prev = 1'b1;
    bit          pending_prev = 1'b0;
    int unsigned c = 0;
    logic [7:0]  cur = '0;
    logic        exp_tx;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        exp_q.delete();
        in_frame     = 1'b0;
        pending_prev = 1'b0;
        chk("rst_tx",    {7'd0, tx_o},         8'd1);
        chk("rst_ready", {7'd0, data_i_ready}, 8'd1);
        chk("rst_busy",  {7'd0, tx_busy_o},    8'd0);
        chk("rst_done",  {7'd0, tx_done_o},    8'd0);
      end else begin
        if (!in_frame && (tx_o == 1'b0 || pending_prev)) begin
          if (pending_prev) chk("start_due", {7'd0, tx_o}, 8'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_start", 8'd1, 8'd0);
          end else begin
            cur      = exp_q.pop_front();
            in_frame = 1'b1;
            c        = 0;
          end
        end
        if (in_frame) begin
          if (c < C)            exp_tx = 1'b0;
          else if (c < 9 * C)   exp_tx = cur[c / C - 1];
          else                  exp_tx = 1'b1;
          chk("frame_tx",   {7'd0, tx_o},      {7'd0, exp_tx});
          chk("frame_done", {7'd0, tx_done_o}, {7'd0, (c == FRAME - 1)});
          chk("frame_busy", {7'd0, tx_busy_o}, 8'd1);
          if (c == FRAME - 1) frames++;
          c++;
          if (c == FRAME) in_frame = 1'b0;
        end else begin
          chk("idle_tx",   {7'd0, tx_o},      8'd1);
          chk("idle_done", {7'd0, tx_done_o}, 8'd0);
          chk("idle_busy", {7'd0, tx_busy_o}, {7'd0, (exp_q.size() != 0)});
        end
        chk("ready", {7'd0, data_i_ready}, {7'd0, (exp_q.size() == 0)});
        pending_prev = (exp_q.size() != 0);
      end
      rst_prev = rst_i;
    end
  end

  // Offer a byte and hold valid until the handshake edge; push it on acceptance.
  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    data_i       = b;
    data_i_valid = 1'b1;
    for (int unsigned i = 0; i < 30 * C && !ok; i++) begin
      @(negedge clk);
      #1;
      if (data_i_ready && !rst_i) begin
        exp_q.push_back(b);
        pushes++;
        ok = 1'b1;
      end
    end
    if (!ok) chk("send_timeout", 8'd1, 8'd0);
    @(posedge clk);
    #1;
    data_i_valid = 1'b0;
    data_i       = 8'($urandom);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit settled = 1'b0;
    rst_i        = 1'b1;
    data_i       = '0;
    data_i_valid = 1'b0;
    idle(3);
    rst_i = 1'b0;
    idle(2);

    send(8'hA5);
    idle(FRAME + 5);

    send(8'h00);
    send(8'hFF);
    idle(2 * FRAME + 5);

    send(8'h11);
    send(8'h22);
    send(8'h33);
    idle(3 * FRAME + 5);

    // Abort during data bit 3 of 0x3C with 0x55 waiting in the holding register.
    send(8'h3C);
    send(8'h55);
    idle(4 * C);
    rst_i = 1'b1;
    idle(3);
    rst_i = 1'b0;
    idle(FRAME);
    send(8'hC3);
    idle(FRAME + 5);

    for (int unsigned i = 0; i < 40; i++) begin
      idle(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 60));
      send(8'($urandom));
    end

    for (int unsigned i = 0; i < 50 * FRAME && !settled; i++) begin
      @(posedge clk);
      #1;
      settled = (exp_q.size() == 0) && !in_frame;
    end
    chk("drain_timeout", {7'd0, settled}, 8'd1);
    idle(5);
    chk("frame_count", 8'(frames), 8'(pushes - 2));
    chk("end_busy",  {7'd0, tx_busy_o},    8'd0);
    chk("end_ready", {7'd0, data_i_ready}, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
